// File: rtl/classificador_pkg.sv
// Shared definitions for the word classifier: FSM states and the classe output codes.
package classificador_pkg;

  typedef enum logic [3:0] {
    INICIO,
    PREFIXO,
    RAIZ,
    ADJ1,
    ADJ2,
    COMP,
    ADV,
    FIM,
    ERRO
  } estado_t;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_ADJ  = 2'b01;
  localparam logic [1:0] CLS_COMP = 2'b10;
  localparam logic [1:0] CLS_ADV  = 2'b11;

  function automatic logic [1:0] classe_de(input estado_t s);
    case (s)
      ADJ1, ADJ2: classe_de = CLS_ADJ;
      COMP:       classe_de = CLS_COMP;
      ADV:        classe_de = CLS_ADV;
      default:    classe_de = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/contador_comprimento.sv
// Letter counter for the current word: clear/start, increment, and a flag at MAX_LEN.
module contador_comprimento #(
  parameter int MAX_LEN = 15
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clr,
  input  logic                           inc,
  output logic [$clog2(MAX_LEN+1)-1:0]   len,
  output logic                           sat
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;

  // clr with inc starts a fresh word at one letter
  always_comb begin
    len_d = len_q;
    if (clr) begin
      len_d = inc ? LEN_W'(1) : '0;
    end else if (inc && !sat) begin
      len_d = len_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  assign len = len_q;
  assign sat = (len_q == LEN_W'(MAX_LEN));

endmodule

// File: rtl/classificador_palavra.sv
// Classifies a word, strobed in symbol by symbol, by its word-final suffix
// (adjective / comparative / adverb), rejecting too-short or too-long words.
module classificador_palavra #(
  parameter int               SYM_W      = 4,
  parameter int               PREFIX_LEN = 2,
  parameter int               MAX_LEN    = 15,
  parameter logic [SYM_W-1:0] SUF_A      = 4'b0110,
  parameter logic [SYM_W-1:0] SUF_B      = 4'b0111,
  parameter logic [SYM_W-1:0] SUF_ADV    = 4'b0111,
  parameter logic [SYM_W-1:0] COMP_1     = 4'b1001,
  parameter logic [SYM_W-1:0] COMP_2     = 4'b1010
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ok,
  input  logic [SYM_W-1:0]             simbolo,
  output logic [1:0]                   classe,
  output logic                         fim,
  output logic                         erro,
  output logic                         valido,
  output logic [$clog2(MAX_LEN+1)-1:0] comprimento
);

  import classificador_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  if (PREFIX_LEN < 1) begin : g_chk_prefix
    $error("classificador_palavra: PREFIX_LEN must be at least 1");
  end
  if (MAX_LEN <= PREFIX_LEN) begin : g_chk_max
    $error("classificador_palavra: MAX_LEN must exceed PREFIX_LEN");
  end
  if ((SUF_A[SYM_W-2:0] == '0) || (SUF_B[SYM_W-2:0] == '0) || (SUF_ADV[SYM_W-2:0] == '0) ||
      (COMP_1[SYM_W-2:0] == '0) || (COMP_2[SYM_W-2:0] == '0)) begin : g_chk_suf
    $error("classificador_palavra: a suffix code would be read as a terminator");
  end

  estado_t          state_q, state_d;
  logic [1:0]       classe_q, classe_d;
  logic             fim_q, fim_d;
  logic             erro_q, erro_d;
  logic             valido_q, valido_d;
  logic             is_term;
  logic             cnt_clr, cnt_inc, len_sat;
  logic [LEN_W-1:0] len_cur;

  contador_comprimento #(
    .MAX_LEN (MAX_LEN)
  ) u_contador (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .len   (len_cur),
    .sat   (len_sat)
  );

  // the tom bit is ignored when spotting a terminator
  assign is_term = (simbolo[SYM_W-2:0] == '0);

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (ok) begin
      if (state_q == INICIO || state_q == FIM || state_q == ERRO) begin
        if (is_term) begin
          state_d = ERRO;
        end else begin
          cnt_clr = 1'b1;
          cnt_inc = 1'b1;
          state_d = (PREFIX_LEN == 1) ? RAIZ : PREFIXO;
        end
      end else if (is_term) begin
        state_d = (state_q == PREFIXO || state_q == RAIZ) ? ERRO : FIM;
      end else if (len_sat) begin
        state_d = ERRO;
      end else begin
        // any letter that does not extend a suffix falls back to the root
        cnt_inc = 1'b1;
        state_d = RAIZ;
        case (state_q)
          PREFIXO: state_d = (len_cur == LEN_W'(PREFIX_LEN - 1)) ? RAIZ : PREFIXO;
          RAIZ: begin
            if (simbolo == SUF_A)      state_d = ADJ1;
            else if (simbolo == SUF_B) state_d = ADJ2;
          end
          ADJ1: begin
            if (simbolo == SUF_ADV)     state_d = ADV;
            else if (simbolo == COMP_1) state_d = COMP;
          end
          ADJ2: begin
            if (simbolo == COMP_2) state_d = COMP;
          end
          default: state_d = RAIZ;
        endcase
      end
    end

    classe_d = classe_q;
    fim_d    = fim_q;
    erro_d   = erro_q;
    valido_d = 1'b0;
    if (ok) begin
      // FIM keeps the class of the suffix state it was reached from
      classe_d = (state_d == FIM) ? classe_de(state_q) : classe_de(state_d);
      fim_d    = (state_d == FIM) || (state_d == ERRO);
      erro_d   = (state_d == ERRO);
      valido_d = fim_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= INICIO;
      classe_q <= CLS_NONE;
      fim_q    <= 1'b0;
      erro_q   <= 1'b0;
      valido_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      classe_q <= classe_d;
      fim_q    <= fim_d;
      erro_q   <= erro_d;
      valido_q <= valido_d;
    end
  end

  assign classe      = classe_q;
  assign fim         = fim_q;
  assign erro        = erro_q;
  assign valido      = valido_q;
  assign comprimento = len_cur;

endmodule

// File: tb/tb_classificador_palavra.sv
// Scoreboard bench for classificador_palavra: a word-level model queues the expected
// outputs for every cycle and an independent monitor compares them on the falling edge.
module tb_classificador_palavra;

  localparam int PL = 2;
  localparam int ML = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       ok;
  logic [3:0] simbolo;
  logic [1:0] classe;
  logic       fim, erro, valido;
  logic [3:0] comprimento;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] classe;
    logic       fim;
    logic       erro;
    logic       valido;
    logic [3:0] len;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [3:0] word[$];
  bit         in_word;

  classificador_palavra dut (
    .clock       (clock),
    .reset       (reset),
    .ok          (ok),
    .simbolo     (simbolo),
    .classe      (classe),
    .fim         (fim),
    .erro        (erro),
    .valido      (valido),
    .comprimento (comprimento)
  );

  always #5 clock = ~clock;

  // Reads the letters after the prefix as a sequence of suffix markers:
  // -1 still in prefix, 0 plain root, 1 ends in -a, 2 ends in -b, 3 comparative, 4 adverb.
  function automatic int tail_kind();
    int k;
    if (word.size() < PL) return -1;
    k = 0;
    for (int i = PL; i < word.size(); i++) begin
      if (k == 0 && word[i] == 4'b0110)      k = 1;
      else if (k == 0 && word[i] == 4'b0111) k = 2;
      else if (k == 1 && word[i] == 4'b0111) k = 4;
      else if (k == 1 && word[i] == 4'b1001) k = 3;
      else if (k == 2 && word[i] == 4'b1010) k = 3;
      else                                   k = 0;
    end
    return k;
  endfunction

  function automatic logic [1:0] class_of(input int k);
    if (k == 1 || k == 2) return 2'b01;
    if (k == 3)           return 2'b10;
    if (k == 4)           return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step(input logic okv, input logic [3:0] s);
    int k;
    @(negedge clock);
    #1;
    ok      = okv;
    simbolo = s;
    cur.valido = 1'b0;
    if (okv) begin
      if (s[2:0] == 3'b000) begin
        k = in_word ? tail_kind() : -1;
        in_word    = 1'b0;
        cur.fim    = 1'b1;
        cur.valido = 1'b1;
        cur.erro   = (k <= 0);
        cur.classe = (k <= 0) ? 2'b00 : class_of(k);
      end else if (!in_word) begin
        word.delete();
        word.push_back(s);
        in_word = 1'b1;
        cur     = '{classe: 2'b00, fim: 1'b0, erro: 1'b0, valido: 1'b0, len: 4'd1};
      end else if (word.size() == ML) begin
        in_word    = 1'b0;
        cur.classe = 2'b00;
        cur.fim    = 1'b1;
        cur.erro   = 1'b1;
        cur.valido = 1'b1;
      end else begin
        word.push_back(s);
        cur.len    = 4'(word.size());
        cur.classe = class_of(tail_kind());
        cur.fim    = 1'b0;
        cur.erro   = 1'b0;
      end
    end
    exp_q.push_back(cur);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    ok    = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_immediate", {23'd0, classe, fim, erro, valido, comprimento}, 32'd0);
    word.delete();
    in_word = 1'b0;
    cur     = '0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({classe, fim, erro, valido, comprimento} !== e) begin
          bad++;
          $display("FAIL scoreboard t=%0t got classe=%b fim=%b erro=%b valido=%b len=%0d want classe=%b fim=%b erro=%b valido=%b len=%0d",
                   $time, classe, fim, erro, valido, comprimento,
                   e.classe, e.fim, e.erro, e.valido, e.len);
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] s;
    reset   = 1'b1;
    ok      = 1'b0;
    simbolo = 4'b0000;
    cur     = '0;
    in_word = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_state", {23'd0, classe, fim, erro, valido, comprimento}, 32'd0);
    #1 reset = 1'b0;

    // adjective, comparative, adverb, fall-back to root
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0110); step(1, 4'b0000); step(0, 4'b0000);
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0110); step(1, 4'b1001); step(1, 4'b0000);
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0110); step(1, 4'b0111); step(1, 4'b0000);
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0110); step(1, 4'b0011); step(1, 4'b0000);
    step(0, 4'b0101);

    // bare terminator with tom set, then a fresh word
    do_reset();
    step(1, 4'b1000); step(0, 4'b0000); step(1, 4'b0001); step(1, 4'b0000);

    // word overflow, then an error re-entry
    for (int i = 0; i < 16; i++) step(1, 4'b0011);
    step(1, 4'b0000); step(0, 4'b0000);

    // reset between edges mid-word
    step(1, 4'b0001); step(1, 4'b0010);
    do_reset();

    // symbol changes without the strobe
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0111);
    for (int i = 0; i < 10; i++) step(0, 4'($urandom_range(0, 15)));
    step(1, 4'b1010); step(1, 4'b0000);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      case ($urandom_range(0, 9))
        0, 1:    s = {1'($urandom_range(0, 1)), 3'b000};
        2:       s = 4'b0110;
        3:       s = 4'b0111;
        4:       s = 4'b1001;
        5:       s = 4'b1010;
        default: s = 4'($urandom_range(0, 15));
      endcase
      step($urandom_range(0, 3) != 0, s);
    end

    @(negedge clock);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/classificador_palavra.md
CLASSIFICADOR_PALAVRA -- requirements
Module: classificador_palavra

Interface
REQ-001 SHALL have parameter SYM_W, default 4, symbol width; the MSB is the "tom" bit.
REQ-002 SHALL have parameter PREFIX_LEN, default 2, the number of letters required before a suffix is recognised.
REQ-003 SHALL have parameter MAX_LEN, default 15, the maximum number of letters in a word.
REQ-004 SHALL have parameters SUF_A=4'b0110, SUF_B=4'b0111, SUF_ADV=4'b0111, COMP_1=4'b1001 and COMP_2=4'b1010, all SYM_W wide, giving the suffix codes.
REQ-005 SHALL use derived width LEN_W = clog2(MAX_LEN+1).
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-008 SHALL have port ok, input, 1 bit: symbol strobe; the symbol is accepted on a rising clock edge with ok=1.
REQ-009 SHALL have port simbolo, input, SYM_W bits: the current symbol.
REQ-010 SHALL have port classe, output, 2 bits: 00 none, 01 adjective, 10 comparative, 11 adverb.
REQ-011 SHALL have port fim, output, 1 bit: word finished (class or error).
REQ-012 SHALL have port erro, output, 1 bit: word rejected.
REQ-013 SHALL have port valido, output, 1 bit: one-cycle pulse on entry to FIM or ERRO.
REQ-014 SHALL have port comprimento, output, LEN_W bits: count of accepted letters.

Function
REQ-015 Terminator SHALL be any symbol with simbolo[SYM_W-2:0]==0, regardless of tom; every other symbol is a letter.
REQ-016 State and outputs SHALL change only on a clock edge with ok=1; symbol changes while ok=0 SHALL have no effect.
REQ-017 States SHALL be INICIO, PREFIXO, RAIZ, ADJ1, ADJ2, COMP, ADV, FIM and ERRO.
REQ-018 Transitions from INICIO, FIM and ERRO SHALL be: letter -> PREFIXO with len=1 (or RAIZ if PREFIX_LEN==1); terminator -> ERRO.
REQ-019 Transitions from PREFIXO SHALL be: terminator -> ERRO; letter -> len+1, moving to RAIZ when len+1==PREFIX_LEN.
REQ-020 Transitions from RAIZ SHALL be: simbolo==SUF_A -> ADJ1; ==SUF_B -> ADJ2; terminator -> ERRO; other letter -> stay in RAIZ.
REQ-021 Transitions from ADJ1 SHALL be: ==SUF_ADV -> ADV; ==COMP_1 -> COMP; terminator -> FIM.
REQ-022 Transitions from ADJ2 SHALL be: ==COMP_2 -> COMP; terminator -> FIM.
REQ-023 Transitions from ADV and COMP SHALL be: terminator -> FIM.
REQ-024 In ADJ1, ADJ2, ADV and COMP, any other letter SHALL return to RAIZ, so that only a word-final suffix classifies.
REQ-025 Suffix comparisons SHALL use all SYM_W bits, including tom; RAIZ checks SUF_A before SUF_B.
REQ-026 Every accepted letter SHALL increment len; a letter accepted when len==MAX_LEN SHALL go to ERRO with len held at MAX_LEN.
REQ-027 classe SHALL be registered and follow the state: ADJ1/ADJ2 = 01, COMP = 10, ADV = 11, all others = 00.
REQ-028 In FIM, classe SHALL hold the class of the state that was left.
REQ-029 fim SHALL be 1 in FIM and in ERRO; erro SHALL be 1 only in ERRO; both SHALL hold until the next accepted symbol.
REQ-030 comprimento SHALL equal len and SHALL be frozen in FIM and ERRO.
REQ-031 valido SHALL be 1 for exactly the one cycle after the edge that enters FIM or ERRO, including an ERRO->ERRO re-entry.
REQ-032 Elaboration SHALL fail if PREFIX_LEN<1, if MAX_LEN<=PREFIX_LEN, or if any suffix code is a terminator.

Reset
REQ-033 reset=1 SHALL immediately, without waiting for a clock edge, force state INICIO, len=0, classe=00, fim=0, erro=0, valido=0 and comprimento=0.
REQ-034 A reset mid-word SHALL abort the word; the first accepted symbol after reset is released SHALL be processed as from INICIO.

Structure
REQ-035 The state enum and the classe encodings (CLS_NONE, CLS_ADJ, CLS_COMP, CLS_ADV) SHALL live in shared package classificador_pkg.
REQ-036 The length counter (increment, saturation flag, clear) SHALL be sub-module contador_comprimento, parameterised by MAX_LEN.

Verification (default parameters)
REQ-037 Symbols 0001, 0010, 0110, 0000 with ok -> classe=01, fim=1, erro=0, comprimento=3, one valido pulse.
REQ-038 Symbols 0001, 0010, 0110, 1001, 0000 -> classe=10 in COMP and FIM, comprimento=4.
REQ-039 Symbols 0001, 0010, 0110, 0111, 0000 -> classe=11, fim=1.
REQ-040 Symbols 0001, 0010, 0110, 0011, 0000 -> back to RAIZ on 0011, then ERRO: erro=1, classe=00.
REQ-041 First symbol 1000 -> ERRO, fim=1, erro=1; next symbol 0001 -> fim=0, erro=0, comprimento=1.
REQ-042 Sixteen symbols 0011 -> ERRO on the 16th with comprimento=15.
REQ-043 Symbols 0001, 0010, then reset pulsed between edges -> all outputs 0 immediately.
REQ-044 Toggling simbolo with ok=0 for 10 cycles -> no change to state or outputs.
